// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem
//  Description : AXI4 slave memory model with independent write/read FSMs,
//                one burst outstanding per direction, byte-strobe writes.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_slave_mem #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int c_STRB_W   = DATA_W / 8;
    localparam int c_BYTE_LSB = $clog2(c_STRB_W);
    localparam int c_IDX_W    = $clog2(MEM_DEPTH);

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    localparam logic [1:0] c_BURST_FIXED = 2'd0;
    localparam logic [1:0] c_BURST_WRAP  = 2'd2;
    localparam logic [1:0] c_BURST_RSVD  = 2'd3;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // WRAP window is (len+1) beats, aligned to its own size.
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                      input logic [1:0]        burst,
                                                      input logic [7:0]        len);
        logic [ADDR_W-1:0] w_inc;
        logic [ADDR_W-1:0] w_mask;
        w_inc  = addr + ADDR_W'(c_STRB_W);
        w_mask = ((ADDR_W'(len) + ADDR_W'(1)) << c_BYTE_LSB) - ADDR_W'(1);
        case (burst)
            c_BURST_FIXED: f_next_addr = addr;
            c_BURST_WRAP:  f_next_addr = (addr & ~w_mask) | (w_inc & w_mask);
            default:       f_next_addr = w_inc;
        endcase
    endfunction

    function automatic logic f_beat_err(input logic [ADDR_W-1:0] addr,
                                        input logic [1:0]        burst,
                                        input logic [7:0]        len);
        logic w_bad_wrap;
        w_bad_wrap = (burst == c_BURST_WRAP) &&
                     !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        f_beat_err = (burst == c_BURST_RSVD) || w_bad_wrap ||
                     (addr[ADDR_W-1:c_BYTE_LSB+c_IDX_W] != '0);
    endfunction

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------ write
    logic [1:0]        r_w_state;
    logic [ID_W-1:0]   r_aw_id;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [7:0]        r_aw_len;
    logic [1:0]        r_aw_burst;
    logic [7:0]        r_aw_cnt;
    logic              r_wr_err;

    logic               w_w_hs;
    logic               w_wr_last;
    logic               w_wr_beat_err;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_wr_idx;

    assign w_w_hs        = wvalid && wready;
    assign w_wr_last     = (r_aw_cnt == r_aw_len);
    assign w_wr_beat_err = f_beat_err(r_aw_addr, r_aw_burst, r_aw_len);
    assign w_wr_en       = w_w_hs && !w_wr_beat_err && !areset;
    assign w_wr_idx      = r_aw_addr[c_BYTE_LSB +: c_IDX_W];

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_w_state  <= c_W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= c_RESP_OKAY;
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_burst <= '0;
            r_aw_cnt   <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            case (r_w_state)
                c_W_IDLE: begin
                    if (awvalid && awready) begin
                        r_aw_id    <= awid;
                        r_aw_addr  <= awaddr;
                        r_aw_len   <= awlen;
                        r_aw_burst <= awburst;
                        r_aw_cnt   <= 8'd0;
                        r_wr_err   <= 1'b0;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        r_w_state  <= c_W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                c_W_DATA: begin
                    // Beat count alone ends the burst; wlast only feeds the error flag.
                    if (w_w_hs) begin
                        if (w_wr_beat_err || (wlast != w_wr_last)) r_wr_err <= 1'b1;
                        r_aw_addr <= f_next_addr(r_aw_addr, r_aw_burst, r_aw_len);
                        r_aw_cnt  <= r_aw_cnt + 8'd1;
                        if (w_wr_last) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bid       <= r_aw_id;
                            bresp     <= (r_wr_err || w_wr_beat_err || (wlast != w_wr_last))
                                         ? c_RESP_SLVERR : c_RESP_OKAY;
                            r_w_state <= c_W_RESP;
                        end
                    end
                end
                c_W_RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready   <= 1'b1;
                        r_w_state <= c_W_IDLE;
                    end
                end
                default: r_w_state <= c_W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    logic [0:0]        r_r_state;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [7:0]        r_ar_len;
    logic [1:0]        r_ar_burst;
    logic [7:0]        r_ar_cnt;

    logic               w_rd_idle;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [1:0]         w_rd_burst;
    logic [7:0]         w_rd_len;
    logic               w_rd_err;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [DATA_W-1:0]  w_rd_word;

    assign w_rd_idle  = (r_r_state == c_R_IDLE);
    assign w_rd_addr  = w_rd_idle ? araddr  : r_ar_addr;
    assign w_rd_burst = w_rd_idle ? arburst : r_ar_burst;
    assign w_rd_len   = w_rd_idle ? arlen   : r_ar_len;
    assign w_rd_err   = f_beat_err(w_rd_addr, w_rd_burst, w_rd_len);
    assign w_rd_idx   = w_rd_addr[c_BYTE_LSB +: c_IDX_W];

    // Forward a same-cycle write so the beat loaded now already sees it.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (wstrb[b]) w_rd_word[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_r_state  <= c_R_IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rid        <= '0;
            rdata      <= '0;
            rresp      <= c_RESP_OKAY;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_burst <= '0;
            r_ar_cnt   <= '0;
        end else begin
            case (r_r_state)
                c_R_IDLE: begin
                    if (arvalid && arready) begin
                        rid        <= arid;
                        r_ar_len   <= arlen;
                        r_ar_burst <= arburst;
                        r_ar_addr  <= f_next_addr(araddr, arburst, arlen);
                        r_ar_cnt   <= 8'd1;
                        rdata      <= w_rd_err ? '0 : w_rd_word;
                        rresp      <= w_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
                        rlast      <= (arlen == 8'd0);
                        rvalid     <= 1'b1;
                        arready    <= 1'b0;
                        r_r_state  <= c_R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                c_R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready   <= 1'b1;
                            r_r_state <= c_R_IDLE;
                        end else begin
                            rdata     <= w_rd_err ? '0 : w_rd_word;
                            rresp     <= w_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
                            rlast     <= (r_ar_cnt == r_ar_len);
                            r_ar_addr <= f_next_addr(r_ar_addr, r_ar_burst, r_ar_len);
                            r_ar_cnt  <= r_ar_cnt + 8'd1;
                        end
                    end
                end
                default: r_r_state <= c_R_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_slave_mem
//  Description : Self-checking bench for axi_slave_mem against a word-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_slave_mem;

    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_DEPTH = 1024;

    logic              aclk, areset;
    logic [ID_W-1:0]   awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata;
    logic [3:0]        wstrb;

    axi_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [MEM_DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id   [256];
    int          rd_stall_changes;
    bit          rd_post_ok;

    // Reference: beat address and error status derived directly from the burst rules.
    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [1:0] burst,
                                           input int len, input int i);
        logic [31:0] size, base;
        size = 32'((len + 1) * 4);
        base = a - (a % size);
        case (burst)
            2'd0:    return a;
            2'd2:    return base + ((a - base + 32'(4 * i)) % size);
            default: return a + 32'(4 * i);
        endcase
    endfunction

    function automatic bit m_bad(input logic [31:0] a, input logic [1:0] burst, input int len);
        return (burst == 2'd3) ||
               (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
               (a >= 32'h1000);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [1:0] burst, input int len,
                           input int wl_mode, output logic [1:0] exp);
        logic [31:0] ba;
        bit err;
        err = (wl_mode != 0);
        for (int i = 0; i <= len; i++) begin
            ba = m_addr(a, burst, len, i);
            if (m_bad(ba, burst, len)) err = 1'b1;
            else for (int b = 0; b < 4; b++)
                if (ws[i][b]) mdl[ba[11:2]][b*8 +: 8] = wd[i][b*8 +: 8];
        end
        exp = err ? 2'b10 : 2'b00;
    endtask

    task automatic tmo(input string what);
        errors++;
        checks++;
        $display("FAIL timeout_%s: no handshake within cycle bound", what);
    endtask

    // wl_mode: 0 wlast on final beat, 1 wlast never, 2 wlast on beat 0 and final
    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input logic [1:0] burst, input int wl_mode, input int bstall,
                            input bit gaps, output logic [1:0] resp, output logic [3:0] rbid,
                            output int hold_viol);
        int n;
        hold_viol = 0;
        resp = 2'bxx;
        rbid = 'x;
        awid = id; awaddr = a; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("aw");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast = (wl_mode == 1) ? 1'b0 : (wl_mode == 2) ? (i == 0 || i == len) : (i == len);
            n = 0;
            while (!wready && n < 200) begin @(posedge aclk); #1; n++; end
            if (n >= 200) tmo("w");
            @(posedge aclk); #1;
            wvalid = 1'b0;
        end
        wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("b");
        resp = bresp;
        rbid = bid;
        for (int k = 0; k < bstall; k++) begin
            if (!bvalid || awready || bresp !== resp) hold_viol++;
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        if (bvalid || !awready) hold_viol++;
    endtask

    // mode: 0 rready always, 1 rready toggles starting low, 2 random rready
    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input logic [1:0] burst, input int mode);
        int n, beat;
        bit stalled, tog, r;
        logic [38:0] saved;
        rd_stall_changes = 0;
        arid = id; araddr = a; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("ar");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        beat = 0; n = 0; stalled = 0; tog = 0; saved = '0;
        while (beat <= len && n < 3000) begin
            if (rvalid) begin
                if (stalled && {rdata, rresp, rlast, rid} !== saved) rd_stall_changes++;
                case (mode)
                    0:       r = 1'b1;
                    1:       begin r = tog; tog = ~tog; end
                    default: r = 1'($urandom_range(0, 1));
                endcase
                rready = r;
                if (r) begin
                    rd_data[beat] = rdata; rd_resp[beat] = rresp;
                    rd_last[beat] = rlast; rd_id[beat] = rid;
                    beat++;
                    stalled = 0;
                end else begin
                    saved = {rdata, rresp, rlast, rid};
                    stalled = 1;
                end
            end else begin
                rready = 1'b0;
            end
            @(posedge aclk); #1;
            n++;
        end
        rready = 1'b0;
        if (n >= 3000) tmo("r");
        rd_post_ok = !rvalid && arready;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b rv=%b rl=%b bid=%h bresp=%h rid=%h rdata=%h rresp=%h, want all 0",
                     awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got awready=%b arready=%b, want 1 1", awready, arready);
        end
    endtask

    task automatic test_fill();
        logic [1:0] resp, exp;
        logic [3:0] b;
        int hv;
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            m_write(32'(blk * 1024), 2'd1, 255, 0, exp);
            do_write(4'(blk), 32'(blk * 1024), 255, 2'd1, 0, 0, 1'b0, resp, b, hv);
            checks++;
            if (resp !== exp || b !== 4'(blk) || hv != 0) begin
                errors++;
                $display("FAIL fill_blk%0d: got bresp=%0d bid=%0d hold_viol=%0d, want bresp=%0d bid=%0d 0",
                         blk, resp, b, hv, exp, blk);
            end
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp, exp;
        logic [3:0] b;
        int hv;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        m_write(32'h10, 2'd1, 3, 0, exp);
        do_write(4'd5, 32'h10, 3, 2'd1, 0, 0, 1'b0, resp, b, hv);
        checks++;
        if (resp !== 2'b00 || b !== 4'd5) begin
            errors++;
            $display("FAIL incr_bresp: got bresp=%0d bid=%0d, want 0 5", resp, b);
        end
        do_read(4'd9, 32'h10, 3, 2'd1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 + 32'(i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3) || rd_id[i] !== 4'd9) begin
                errors++;
                $display("FAIL incr_beat%0d: got data=%h resp=%0d last=%b id=%0d, want data=%h resp=0 last=%b id=9",
                         i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], 32'hA0 + 32'(i), (i == 3));
            end
        end
        checks++;
        if (!rd_post_ok) begin
            errors++;
            $display("FAIL incr_rdone: got rvalid=%b arready=%b, want 0 1", rvalid, arready);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] resp, exp;
        logic [3:0] b;
        logic [31:0] want [4];
        int hv;
        want[0] = 32'h38; want[1] = 32'h3C; want[2] = 32'h30; want[3] = 32'h34;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h30 + 32'(4 * i); ws[i] = 4'hF; end
        m_write(32'h30, 2'd1, 3, 0, exp);
        do_write(4'd1, 32'h30, 3, 2'd1, 0, 0, 1'b0, resp, b, hv);
        do_read(4'd2, 32'h38, 3, 2'd2, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== want[i] || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d: got data=%h resp=%0d last=%b, want data=%h resp=0 last=%b",
                         i, rd_data[i], rd_resp[i], rd_last[i], want[i], (i == 3));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp, exp;
        logic [3:0] b;
        int hv;
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        m_write(32'h0, 2'd1, 0, 0, exp);
        do_write(4'd3, 32'h0, 0, 2'd1, 0, 0, 1'b0, resp, b, hv);
        wd[0] = 32'h1234_5678; ws[0] = 4'h5;
        m_write(32'h0, 2'd1, 0, 0, exp);
        do_write(4'd3, 32'h0, 0, 2'd1, 0, 0, 1'b0, resp, b, hv);
        do_read(4'd4, 32'h0, 0, 2'd1, 0);
        checks++;
        if (rd_data[0] !== 32'hFF34_FF78 || rd_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL strobe_merge: got data=%h last=%b, want ff34ff78 1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp, exp;
        logic [3:0] b;
        logic [31:0] ba, ed;
        int hv;
        logic [31:0] addrs [4];
        int lens [4], modes [4];
        logic [1:0] bursts [4];
        addrs[0] = 32'h1000; lens[0] = 0; bursts[0] = 2'd1; modes[0] = 0;
        addrs[1] = 32'h40;   lens[1] = 2; bursts[1] = 2'd2; modes[1] = 0;
        addrs[2] = 32'h50;   lens[2] = 1; bursts[2] = 2'd1; modes[2] = 1;
        addrs[3] = 32'h60;   lens[3] = 2; bursts[3] = 2'd1; modes[3] = 2;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i <= lens[c]; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            m_write(addrs[c], bursts[c], lens[c], modes[c], exp);
            do_write(4'd6, addrs[c], lens[c], bursts[c], modes[c], 0, 1'b0, resp, b, hv);
            checks++;
            if (resp !== 2'b10) begin
                errors++;
                $display("FAIL err_case%0d_bresp: got %0d, want 2", c, resp);
            end
            do_read(4'd7, addrs[c], lens[c], bursts[c], 0);
            for (int i = 0; i <= lens[c]; i++) begin
                ba = m_addr(addrs[c], bursts[c], lens[c], i);
                ed = m_bad(ba, bursts[c], lens[c]) ? 32'h0 : mdl[ba[11:2]];
                checks++;
                if (rd_data[i] !== ed || rd_resp[i] !== (m_bad(ba, bursts[c], lens[c]) ? 2'b10 : 2'b00)) begin
                    errors++;
                    $display("FAIL err_case%0d_beat%0d: got data=%h resp=%0d, want data=%h resp=%0d",
                             c, i, rd_data[i], rd_resp[i], ed, m_bad(ba, bursts[c], lens[c]) ? 2 : 0);
                end
            end
        end
        // The out-of-range and bad-WRAP bursts must not have touched word 0x40..0x48.
        ed = mdl[32'h40 >> 2];
        do_read(4'd8, 32'h40, 0, 2'd1, 0);
        checks++;
        if (rd_data[0] !== ed) begin
            errors++;
            $display("FAIL err_nowrite: got %h, want %h", rd_data[0], ed);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp, exp;
        logic [3:0] b;
        int hv;
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        m_write(32'h100, 2'd1, 7, 0, exp);
        do_write(4'd10, 32'h100, 7, 2'd1, 0, 5, 1'b0, resp, b, hv);
        checks++;
        if (hv != 0 || resp !== 2'b00 || b !== 4'd10) begin
            errors++;
            $display("FAIL bp_bhold: got hold_viol=%0d bresp=%0d bid=%0d, want 0 0 10", hv, resp, b);
        end
        do_read(4'd11, 32'h100, 7, 2'd1, 1);
        checks++;
        if (rd_stall_changes != 0) begin
            errors++;
            $display("FAIL bp_rstable: got %0d changes while stalled, want 0", rd_stall_changes);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data[i] !== mdl[(32'h100 >> 2) + i] || rd_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b, want data=%h last=%b",
                         i, rd_data[i], rd_last[i], mdl[(32'h100 >> 2) + i], (i == 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp, exp;
        logic [3:0] b;
        int hv, n;
        awid = 4'd12; awaddr = 32'h200; awlen = 8'd3; awburst = 2'd1; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("rm_aw");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wlast = 1'b0;
            n = 0;
            while (!wready && n < 200) begin @(posedge aclk); #1; n++; end
            if (n >= 200) tmo("rm_w");
            @(posedge aclk); #1;
        end
        wdata = $urandom;
        areset = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_abandon: got wready=%b bvalid=%b, want 0 0", wready, bvalid);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_release: got awready=%b bvalid=%b, want 1 0", awready, bvalid);
        end
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        m_write(32'h200, 2'd1, 3, 0, exp);
        do_write(4'd13, 32'h200, 3, 2'd1, 0, 0, 1'b0, resp, b, hv);
        checks++;
        if (resp !== 2'b00 || b !== 4'd13) begin
            errors++;
            $display("FAIL rm_fresh_bresp: got bresp=%0d bid=%0d, want 0 13", resp, b);
        end
        do_read(4'd14, 32'h200, 3, 2'd1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== wd[i]) begin
                errors++;
                $display("FAIL rm_fresh_beat%0d: got %h, want %h", i, rd_data[i], wd[i]);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] oldv, newv;
        int n;
        oldv = mdl[32'h300 >> 2];
        newv = ~oldv;
        arid = 4'd3; araddr = 32'h300; arlen = 8'd1; arburst = 2'd0; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("col_ar");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        awid = 4'd2; awaddr = 32'h300; awlen = 8'd0; awburst = 2'd1; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("col_aw");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1 || rvalid !== 1'b1 || rdata !== oldv) begin
            errors++;
            $display("FAIL col_before: got wready=%b rvalid=%b rdata=%h, want 1 1 %h", wready, rvalid, rdata, oldv);
        end
        wvalid = 1'b1; wdata = newv; wstrb = 4'hF; wlast = 1'b1; rready = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        mdl[32'h300 >> 2] = newv;
        checks++;
        if (rvalid !== 1'b1 || rdata !== newv || rlast !== 1'b1) begin
            errors++;
            $display("FAIL col_forward: got rvalid=%b rdata=%h rlast=%b, want 1 %h 1", rvalid, rdata, rlast, newv);
        end
        @(posedge aclk); #1;
        rready = 1'b0;
        n = 0;
        while (!bvalid && n < 200) begin @(posedge aclk); #1; n++; end
        if (n >= 200) tmo("col_b");
        checks++;
        if (bresp !== 2'b00 || bid !== 4'd2) begin
            errors++;
            $display("FAIL col_bresp: got bresp=%0d bid=%0d, want 0 2", bresp, bid);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] resp, exp, burst, er;
        logic [3:0] b, id;
        logic [31:0] a, ba, ed;
        int len, wl, hv;
        bit bad;
        for (int it = 0; it < 40; it++) begin
            id = 4'($urandom);
            burst = 2'($urandom_range(0, 3));
            if (burst == 2'd2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            else len = $urandom_range(0, 15);
            a = 32'($urandom_range(0, 1100)) * 4;
            wl = ($urandom_range(0, 7) == 0) ? 1 : 0;
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            m_write(a, burst, len, wl, exp);
            do_write(id, a, len, burst, wl, $urandom_range(0, 3), 1'b1, resp, b, hv);
            checks++;
            if (resp !== exp || b !== id || hv != 0) begin
                errors++;
                $display("FAIL rand%0d_b: got bresp=%0d bid=%0d hold_viol=%0d, want bresp=%0d bid=%0d 0",
                         it, resp, b, hv, exp, id);
            end
            do_read(~id, a, len, burst, 2);
            for (int i = 0; i <= len; i++) begin
                ba = m_addr(a, burst, len, i);
                bad = m_bad(ba, burst, len);
                ed = bad ? 32'h0 : mdl[ba[11:2]];
                er = bad ? 2'b10 : 2'b00;
                checks++;
                if (rd_data[i] !== ed || rd_resp[i] !== er || rd_last[i] !== (i == len) || rd_id[i] !== ~id) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got data=%h resp=%0d last=%b id=%0d, want data=%h resp=%0d last=%b id=%0d",
                             it, i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], ed, er, (i == len), ~id);
                end
            end
            checks++;
            if (rd_stall_changes != 0 || !rd_post_ok) begin
                errors++;
                $display("FAIL rand%0d_rflow: got stall_changes=%0d post_ok=%b, want 0 1", it, rd_stall_changes, rd_post_ok);
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_fill();
        test_incr();
        test_wrap();
        test_strobe();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
